// File: rtl/inst_loader.sv
// Instruction BRAM loader: packs a big-endian UART byte stream into 32-bit words and writes them
// from address 0 until the END_WORD sentinel or memory-full. Optional macro: LOADER_ACK_EN (ack byte to uart_tx).
module inst_loader #(
    parameter int          ADDR_W   = 15,
    parameter logic [31:0] END_WORD = 32'h0000003F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_din,
    output logic              bram_we,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count,
    output logic [7:0]        ack_data,
    output logic              ack_valid,
    input  logic              ack_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_ACK  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  byte_idx;
    logic [23:0] shift_q;
    logic        last_write;
    logic        start_ok;

    // The write in flight ends the load if it carries the sentinel or fills the top word.
    assign last_write = (state == S_RECV) && bram_we && ((bram_din == END_WORD) || (&bram_addr));
    assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_RECV;
            S_RECV: begin
                if (last_write) begin
`ifdef LOADER_ACK_EN
                    state_nxt = S_ACK;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
`ifdef LOADER_ACK_EN
            S_ACK:   if (ack_ready) state_nxt = S_DONE;
`else
            S_ACK:   state_nxt = S_DONE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_RECV);
    assign done = (state == S_DONE);

`ifdef LOADER_ACK_EN
    assign ack_valid = (state == S_ACK);
    assign ack_data  = (state == S_ACK) ? (overflow ? 8'hEE : 8'hAA) : 8'h00;
`else
    logic unused_ack_ready;
    assign unused_ack_ready = ack_ready;
    assign ack_valid        = 1'b0;
    assign ack_data         = 8'h00;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bram_addr  <= '0;
            bram_din   <= '0;
            bram_we    <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
            byte_idx   <= 2'd0;
            shift_q    <= '0;
        end else begin
            bram_we <= 1'b0;
            if (start_ok) begin
                word_count <= '0;
                overflow   <= 1'b0;
                byte_idx   <= 2'd0;
            end
            if (state == S_RECV) begin
                // A byte arriving alongside the write pulse already belongs to the next word.
                if (rx_valid) begin
                    shift_q  <= {shift_q[15:0], rx_data};
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        bram_we   <= 1'b1;
                        bram_din  <= {shift_q, rx_data};
                        bram_addr <= word_count[ADDR_W-1:0];
                    end
                end
                if (bram_we) begin
                    word_count <= word_count + 1'b1;
                    if ((bram_din != END_WORD) && (&bram_addr)) overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: write-port scoreboard plus table-driven load sequences.
module tb_inst_loader;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst, start, rx_valid, ack_ready;
    logic [7:0]    rx_data;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_din;
    logic          bram_we, busy, done, overflow;
    logic [AW:0]   word_count;
    logic [7:0]    ack_data;
    logic          ack_valid;

    inst_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
        .busy(busy), .done(done), .overflow(overflow), .word_count(word_count),
        .ack_data(ack_data), .ack_valid(ack_valid), .ack_ready(ack_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; logic [31:0] din; } wr_t;
    typedef struct { logic [31:0] word; bit gap; int exp_wc; bit exp_ovf; bit exp_busy; } vec_t;

    wr_t           exp_q[$];
    wr_t           mon_exp;
    logic [AW-1:0] exp_addr;
    int            n_chk = 0;
    int            n_pass = 0;
    vec_t          load_tab[3];
    vec_t          ovf_tab[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    always @(negedge clk) begin
        if (bram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_write: addr %0h din %0h, no write expected", bram_addr, bram_din);
            end else begin
                mon_exp = exp_q.pop_front();
                check("write_addr", 64'(bram_addr), 64'(mon_exp.addr));
                check("write_din", 64'(bram_din), 64'(mon_exp.din));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit expect_wr);
        if (expect_wr) begin
            exp_q.push_back('{exp_addr, w});
            exp_addr++;
        end
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_addr = '0;
        check("start_busy", 64'(busy), 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        send_word(v.word, 1'b1);
        if (v.gap) begin
            tick();
            check("word_count", 64'(word_count), 64'(v.exp_wc));
            check("overflow", 64'(overflow), 64'(v.exp_ovf));
            check("busy", 64'(busy), 64'(v.exp_busy));
        end
    endtask

    task automatic post_load(input logic [7:0] exp_ack);
`ifdef LOADER_ACK_EN
        ack_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ack_valid_wait", 64'(ack_valid), 64'd1);
            check("ack_data_wait", 64'(ack_data), 64'(exp_ack));
            check("done_before_ack", 64'(done), 64'd0);
            tick();
        end
        ack_ready = 1'b1;
        check("ack_data_hs", 64'(ack_data), 64'(exp_ack));
        tick();
        ack_ready = 1'b0;
        check("done_after_ack", 64'(done), 64'd1);
        check("ack_valid_after", 64'(ack_valid), 64'd0);
`else
        check("done_after_load", 64'(done), 64'd1);
        check("ack_valid_off", 64'(ack_valid), 64'd0);
        check("ack_data_off", 64'(ack_data), 64'(exp_ack & 8'h00));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, 64'(bram_we), 64'd0);
        check({tag, "_addr"}, 64'(bram_addr), 64'd0);
        check({tag, "_din"}, 64'(bram_din), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_ovf"}, 64'(overflow), 64'd0);
        check({tag, "_wc"}, 64'(word_count), 64'd0);
        check({tag, "_ackv"}, 64'(ack_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        load_tab[0] = '{32'h12345678, 1'b1, 1, 1'b0, 1'b1};
        load_tab[1] = '{32'h9ABCDEF0, 1'b0, 0, 1'b0, 1'b1};
        load_tab[2] = '{32'h0000003F, 1'b1, 3, 1'b0, 1'b0};
        ovf_tab[0]  = '{32'hA1A2A3A4, 1'b1, 1, 1'b0, 1'b1};
        ovf_tab[1]  = '{32'hB1B2B3B4, 1'b1, 2, 1'b0, 1'b1};
        ovf_tab[2]  = '{32'hC1C2C3C4, 1'b1, 3, 1'b0, 1'b1};
        ovf_tab[3]  = '{32'hD1D2D3D4, 1'b1, 4, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; ack_ready = 1'b0;
        exp_addr = '0;
        #1;
        check_all_zero("reset");
        tick(); tick();
        rst = 1'b0;
        tick();
        send_byte(8'h55);                // ignored in IDLE
        check("idle_busy", 64'(busy), 64'd0);

        // Basic load, back-to-back word boundary, sentinel stop.
        do_start();
        for (int i = 0; i < 3; i++) begin
            run_vec(load_tab[i]);
            if (i == 0) check("done_mid", 64'(done), 64'd0);
        end
        post_load(8'hAA);
        send_word(32'h11223344, 1'b0);   // after sentinel: no writes
        tick(); tick();
        check("wc_after_sentinel", 64'(word_count), 64'd3);

        // Memory-full: four words fill ADDR_W=2, fifth never written.
        do_start();
        check("start_clears_wc", 64'(word_count), 64'd0);
        for (int i = 0; i < 4; i++) run_vec(ovf_tab[i]);
        post_load(8'hEE);
        send_word(32'hE1E2E3E4, 1'b0);
        tick(); tick();
        check("ovf_sticky", 64'(overflow), 64'd1);
        check("ovf_wc_hold", 64'(word_count), 64'd4);
        do_start();
        check("start_clears_ovf", 64'(overflow), 64'd0);
        check("start_clears_wc2", 64'(word_count), 64'd0);

        // Async reset with two bytes pending, then a clean load.
        send_byte(8'hDE);
        send_byte(8'hAD);
        #3 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        tick();
        rst = 1'b0;
        tick();
        do_start();
        send_word(32'hCAFEBABE, 1'b1);
        tick();
        check("wc_after_rst_load", 64'(word_count), 64'd1);
        tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
